// File: rtl/bcd_chain_counter.sv
// bcd_chain_counter: cascaded BCD digit counter with per-digit maxima,
// load with clamping, run/pause control and a terminal-value done pulse.
// Optional feature macro: BCD_CHAIN_COUNTER_SAT_EN. When it is defined,
// reaching the terminal value saturates the counter in EXPIRED. When it is
// not defined, the counter wraps and keeps running.
module bcd_chain_counter #(
    parameter int                      NUM_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX  = 16'h5959
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    up,
    input  logic                    tick,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    running,
    output logic                    expired,
    output logic                    at_term,
    output logic                    done
);

    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   count_reg, count_next;
    logic           done_reg, done_next;

    logic [W-1:0]            clamp_value;   // load_value with each digit limited to its max
    logic [W-1:0]            step_value;    // count after one tick in the current direction
    logic [W-1:0]            term_value;    // terminal value for the current direction
    logic [NUM_DIGITS-1:0]   chain;         // digit gi is allowed to move on this tick
    logic                    start_blocked; // start suppressed while sitting on the terminal value

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam logic [3:0] DMAX = DIGIT_MAX[4*gi +: 4];

            // Elaboration-time guard: a digit maximum must be a usable BCD value.
            if (DMAX < 4'd1 || DMAX > 4'd9) begin : g_bad_cfg
                $error("bcd_chain_counter: DIGIT_MAX nibble out of range 1..9");
            end

            logic [3:0] dig;
            logic [3:0] ld_dig;
            assign dig    = count_reg[4*gi +: 4];
            assign ld_dig = load_value[4*gi +: 4];

            assign clamp_value[4*gi +: 4] = (ld_dig > DMAX) ? DMAX : ld_dig;
            assign term_value[4*gi +: 4]  = up ? DMAX : 4'd0;

            // Digit 0 always moves; higher digits move when every lower digit
            // is at its rollover point (max when counting up, zero when down).
            if (gi == 0) begin : g_first
                assign chain[0] = 1'b1;
            end
            if (gi < NUM_DIGITS - 1) begin : g_carry
                assign chain[gi+1] = chain[gi] & (up ? (dig == DMAX) : (dig == 4'd0));
            end

            assign step_value[4*gi +: 4] =
                !chain[gi] ? dig :
                up         ? ((dig == DMAX) ? 4'd0 : dig + 4'd1) :
                             ((dig == 4'd0) ? DMAX : dig - 4'd1);
        end
    endgenerate

    assign at_term = (count_reg == term_value);

`ifdef BCD_CHAIN_COUNTER_SAT_EN
    assign start_blocked = at_term;
`else
    assign start_blocked = 1'b0;
`endif

    // Next-state logic: load beats stop beats start beats tick.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        if (load) begin
            count_next = clamp_value;
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && !stop && !start_blocked) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_next = ST_IDLE;
                    end else if (tick) begin
                        count_next = step_value;
                        if (step_value == term_value) begin
                            done_next = 1'b1;
`ifdef BCD_CHAIN_COUNTER_SAT_EN
                            state_next = ST_EXPIRED;
`endif
                        end
                    end
                end
                ST_EXPIRED: begin
                    state_next = ST_EXPIRED;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, count and done registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    assign count   = count_reg;
    assign done    = done_reg;
    assign running = (state_reg == ST_RUN);
`ifdef BCD_CHAIN_COUNTER_SAT_EN
    assign expired = (state_reg == ST_EXPIRED);
`else
    assign expired = 1'b0;
`endif

endmodule
